// File: rtl/rv32_boot_loader.sv
// ============================================================================
//  Module   : rv32_boot_loader
//  Function : Receives a framed byte-stream program image, writes it into the
//             RV32 instruction memory and releases the core after a valid
//             checksum.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rv32_boot_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_RUN    = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [32:0] c_capacity = 33'd1 << ADDR_W;

    state_t              r_state;
    logic [7:0]          r_len_lo;
    logic [15:0]         r_len;
    logic [15:0]         r_word_idx;
    logic [1:0]          r_byte_cnt;
    logic [7:0]          r_csum;
    logic [23:0]         r_word;
    logic [ADDR_W-1:0]   r_next_addr;
    logic                r_rx_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_core_rst;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_accept;
    logic [15:0]         w_len;
    logic                w_len_too_big;
    logic                w_last_word;

    assign w_accept      = rx_valid && r_rx_ready;
    assign w_len         = {rx_data, r_len_lo};
    assign w_len_too_big = ({17'd0, w_len} > c_capacity);
    assign w_last_word   = (r_word_idx == (r_len - 16'd1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_LEN_LO;
            r_len_lo    <= 8'd0;
            r_len       <= 16'd0;
            r_word_idx  <= 16'd0;
            r_byte_cnt  <= 2'd0;
            r_csum      <= 8'd0;
            r_word      <= 24'd0;
            r_next_addr <= ADDR_W'(BASE_ADDR);
            r_rx_ready  <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_core_rst  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_LEN_LO: begin
                        r_len_lo <= rx_data;
                        r_csum   <= r_csum + rx_data;
                        r_busy   <= 1'b1;
                        r_state  <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        r_len  <= w_len;
                        r_csum <= r_csum + rx_data;
                        if (w_len_too_big) begin
                            r_state    <= S_ERR;
                            r_err      <= 1'b1;
                            r_busy     <= 1'b0;
                            r_rx_ready <= 1'b0;
                        end else if (w_len == 16'd0) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_csum     <= r_csum + rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0: r_word[7:0]   <= rx_data;
                            2'd1: r_word[15:8]  <= rx_data;
                            2'd2: r_word[23:16] <= rx_data;
                            default: begin
                                // Lane 3 completes the word; the pulse appears next cycle.
                                r_we        <= 1'b1;
                                r_addr      <= r_next_addr;
                                r_wdata     <= {rx_data, r_word};
                                r_next_addr <= r_next_addr + 1'b1;
                                r_word_idx  <= r_word_idx + 16'd1;
                                if (w_last_word) begin
                                    r_state <= S_CSUM;
                                end
                            end
                        endcase
                    end
                    S_CSUM: begin
                        r_busy     <= 1'b0;
                        r_rx_ready <= 1'b0;
                        if (rx_data == r_csum) begin
                            r_state    <= S_RUN;
                            r_done     <= 1'b1;
                            r_core_rst <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rx_ready   = r_rx_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_rst   = r_core_rst;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rv32_boot_loader.sv
// ============================================================================
//  Module   : tb_rv32_boot_loader
//  Function : Directed self-checking bench for rv32_boot_loader.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rv32_boot_loader;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic        watch_en = 1'b0;
    logic        core_rst_seen = 1'b0;

    logic [7:0] frame [0:10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                                 8'h93, 8'h05, 8'h20, 8'h00, 8'hE2};

    rv32_boot_loader #(
        .ADDR_W    (8),
        .BASE_ADDR (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
        end
        if (watch_en && core_rst) core_rst_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the edge that sampled the byte.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic send_frame(input logic [7:0] csum, input bit gaps, input int count);
        for (int i = 0; i < count; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            send_byte((i == 10) ? csum : frame[i]);
        end
    endtask

    task automatic check_two_words(input string tag);
        check({tag, "_nwr"}, 32'(wa_q.size()), 32'd2);
        if (wa_q.size() >= 2) begin
            check({tag, "_a0"}, 32'(wa_q[0]), 32'd0);
            check({tag, "_d0"}, wd_q[0], 32'h00100513);
            check({tag, "_a1"}, 32'(wa_q[1]), 32'd1);
            check({tag, "_d1"}, wd_q[1], 32'h00200593);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(posedge clk);
        #1;
        do_reset();

        // Reset values
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_core_rst", 32'(core_rst), 32'd0);
        check("rst_we",       32'(imem_we), 32'd0);
        check("rst_addr",     32'(imem_addr), 32'd0);
        check("rst_wdata",    imem_wdata, 32'd0);
        check("rst_flags",    {29'd0, busy, done, err}, 32'd0);

        // Two-word frame, good checksum, with pulse timing checks
        send_byte(frame[0]);
        check("s1_busy", 32'(busy), 32'd1);
        for (int i = 1; i < 6; i++) send_byte(frame[i]);
        check("s1_we0",    32'(imem_we), 32'd1);
        check("s1_addr0",  32'(imem_addr), 32'd0);
        check("s1_wdata0", imem_wdata, 32'h00100513);
        send_byte(frame[6]);
        check("s1_we_pulse", 32'(imem_we), 32'd0);
        for (int i = 7; i < 10; i++) send_byte(frame[i]);
        check("s1_we1",     32'(imem_we), 32'd1);
        check("s1_addr1",   32'(imem_addr), 32'd1);
        check("s1_wdata1",  imem_wdata, 32'h00200593);
        check("s1_pre_core", 32'(core_rst), 32'd0);
        check("s1_pre_done", 32'(done), 32'd0);
        send_byte(frame[10]);
        check("s1_done",     32'(done), 32'd1);
        check("s1_core_rst", 32'(core_rst), 32'd1);
        check("s1_err",      32'(err), 32'd0);
        check("s1_rx_ready", 32'(rx_ready), 32'd0);
        check("s1_busy_end", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check_two_words("s1");

        // Zero-length frame
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        check("s2_pre_done", 32'(done), 32'd0);
        send_byte(8'h00);
        check("s2_done",     32'(done), 32'd1);
        check("s2_core_rst", 32'(core_rst), 32'd1);
        @(posedge clk);
        #1;
        check("s2_nwr", 32'(wa_q.size()), 32'd0);

        // Bad checksum
        do_reset();
        send_frame(8'hE3, 1'b0, 11);
        check("s3_err",      32'(err), 32'd1);
        check("s3_done",     32'(done), 32'd0);
        check("s3_core_rst", 32'(core_rst), 32'd0);
        check("s3_rx_ready", 32'(rx_ready), 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rx_valid = 1'b0;
        check("s3_err_hold",  32'(err), 32'd1);
        check("s3_done_hold", 32'(done), 32'd0);
        check("s3_core_hold", 32'(core_rst), 32'd0);
        check_two_words("s3");

        // Oversized length (N = 257 > 256)
        do_reset();
        send_byte(8'h01);
        send_byte(8'h01);
        check("s4_err",      32'(err), 32'd1);
        check("s4_rx_ready", 32'(rx_ready), 32'd0);
        check("s4_busy",     32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("s4_nwr", 32'(wa_q.size()), 32'd0);

        // Two-word frame with idle gaps
        do_reset();
        send_frame(8'hE2, 1'b1, 11);
        check("s5_done",     32'(done), 32'd1);
        check("s5_core_rst", 32'(core_rst), 32'd1);
        check("s5_err",      32'(err), 32'd0);
        @(posedge clk);
        #1;
        check_two_words("s5");

        // Reset mid-load, then full reload
        do_reset();
        core_rst_seen = 1'b0;
        watch_en      = 1'b1;
        send_frame(8'hE2, 1'b0, 6);
        @(posedge clk);
        #1;
        check("s6_partial_nwr", 32'(wa_q.size()), 32'd1);
        do_reset();
        check("s6_rst_core",  32'(core_rst), 32'd0);
        check("s6_rst_busy",  32'(busy), 32'd0);
        check("s6_rst_ready", 32'(rx_ready), 32'd1);
        check("s6_core_seen", 32'(core_rst_seen), 32'd0);
        watch_en = 1'b0;
        send_frame(8'hE2, 1'b0, 11);
        check("s6_done",     32'(done), 32'd1);
        check("s6_core_rst", 32'(core_rst), 32'd1);
        @(posedge clk);
        #1;
        check_two_words("s6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
